// File: rtl/mcp_rx_fsm_if.sv
// Receive-side bundle of the multi-cycle-path handshake: sender toggle/data,
// consumer accept, and the captured word with its status back.
interface mcp_rx_fsm_if #(
    parameter int DATA_W = 8
);
    logic              a_en_tgl;
    logic [DATA_W-1:0] adata;
    logic              bload;
    logic              bvalid;
    logic [DATA_W-1:0] bdata;
    logic              b_ack_tgl;
    logic              overrun;
    logic [7:0]        rx_cnt;

    modport master (
        output a_en_tgl, adata, bload,
        input  bvalid, bdata, b_ack_tgl, overrun, rx_cnt
    );

    modport slave (
        input  a_en_tgl, adata, bload,
        output bvalid, bdata, b_ack_tgl, overrun, rx_cnt
    );
endinterface

// File: rtl/mcp_rx_fsm.sv
// Receive side of a toggle-based multi-cycle-path crossing: synchronises the
// send toggle, captures the held word, and returns an ack toggle per accept.
module mcp_rx_fsm #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic           clk_b,
    input  logic           rstn_b,
    mcp_rx_fsm_if.slave    bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic                   load_pulse;

    state_t                 state_reg, state_next;
    logic [DATA_W-1:0]      bdata_reg, bdata_next;
    logic                   ack_reg, ack_next;
    logic                   overrun_reg, overrun_next;
    logic [7:0]             cnt_reg, cnt_next;

    // adata is only ever sampled on a load_pulse, by which point the sender
    // has held it stable for the whole synchroniser latency.
    always_ff @(posedge clk_b) begin
        if (!rstn_b) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.a_en_tgl};
            edge_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign load_pulse = sync_reg[SYNC_STAGES-1] ^ edge_reg;

    always_ff @(posedge clk_b) begin
        if (!rstn_b) begin
            state_reg   <= IDLE;
            bdata_reg   <= '0;
            ack_reg     <= 1'b0;
            overrun_reg <= 1'b0;
            cnt_reg     <= 8'd0;
        end else begin
            state_reg   <= state_next;
            bdata_reg   <= bdata_next;
            ack_reg     <= ack_next;
            overrun_reg <= overrun_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bdata_next   = bdata_reg;
        ack_next     = ack_reg;
        overrun_next = overrun_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (load_pulse) begin
                    state_next = VALID;
                    bdata_next = bus.adata;
                end
            end
            VALID: begin
                // A new word while one is still held is dropped, never queued.
                if (load_pulse) begin
                    overrun_next = 1'b1;
                end
                if (bus.bload) begin
                    state_next = IDLE;
                    ack_next   = ~ack_reg;
                    cnt_next   = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.bvalid    = (state_reg == VALID);
    assign bus.bdata     = bdata_reg;
    assign bus.b_ack_tgl = ack_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.rx_cnt    = cnt_reg;
endmodule

// File: tb/tb_mcp_rx_fsm.sv
// Randomised and directed bench for mcp_rx_fsm against a cycle-level
// reference model of the toggle handshake rules.
module tb_mcp_rx_fsm;
    localparam int DW = 8;
    localparam int S  = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mcp_rx_fsm_if #(.DATA_W(DW)) bus ();

    mcp_rx_fsm #(.DATA_W(DW), .SYNC_STAGES(S)) dut (
        .clk_b  (clk),
        .rstn_b (rstn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int xfers  = 0;

    // Reference model state
    bit         m_valid, m_ack, m_ovr, m_lvl;
    logic [7:0] m_data, m_cnt;
    int         evq[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then
    // compare every output slightly after the edge.
    task automatic tick();
        bit pulse;
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            m_valid = 0; m_ack = 0; m_ovr = 0; m_lvl = 0;
            m_data  = 8'h00; m_cnt = 8'h00;
            evq.delete();
        end else begin
            pulse = 0;
            if (evq.size() > 0 && evq[0] == cyc) begin
                pulse = 1;
                void'(evq.pop_front());
            end
            // A level change first seen at edge k is acted on at edge k+S.
            if (bus.a_en_tgl != m_lvl) begin
                m_lvl = bus.a_en_tgl;
                evq.push_back(cyc + S);
            end
            if (!m_valid) begin
                if (pulse) begin
                    m_valid = 1;
                    m_data  = bus.adata;
                end
            end else begin
                if (pulse) m_ovr = 1;
                if (bus.bload) begin
                    m_valid = 0;
                    m_ack   = ~m_ack;
                    m_cnt   = m_cnt + 8'd1;
                    xfers++;
                    $display("xfer %0d: data=%02h rx_cnt=%0d ack=%0b overrun=%0b",
                             xfers, m_data, m_cnt, m_ack, m_ovr);
                end
            end
        end
        #1;
        check("bvalid",    bus.bvalid,    m_valid);
        if (m_valid) check("bdata", bus.bdata, m_data);
        check("b_ack_tgl", bus.b_ack_tgl, m_ack);
        check("overrun",   bus.overrun,   m_ovr);
        check("rx_cnt",    bus.rx_cnt,    m_cnt);
    endtask

    task automatic send(logic [7:0] d);
        bus.adata    = d;
        bus.a_en_tgl = ~bus.a_en_tgl;
    endtask

    task automatic wait_valid(int budget);
        int n = 0;
        while (bus.bvalid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_bvalid", bus.bvalid, 1'b1);
    endtask

    task automatic do_reset(int n);
        rstn = 1'b0;
        repeat (n) tick();
        rstn = 1'b1;
    endtask

    initial begin
        bus.a_en_tgl = 1'b0;
        bus.adata    = '0;
        bus.bload    = 1'b0;

        do_reset(3);
        check("rst_bvalid",  bus.bvalid,    1'b0);
        check("rst_bdata",   bus.bdata,     8'h00);
        check("rst_ack",     bus.b_ack_tgl, 1'b0);
        check("rst_overrun", bus.overrun,   1'b0);
        check("rst_cnt",     bus.rx_cnt,    8'd0);

        // Basic transfer and latency
        bus.bload = 1'b1;
        send(8'hA5);
        tick();
        tick();
        check("e2_bvalid", bus.bvalid, 1'b0);
        tick();
        check("e3_bvalid", bus.bvalid, 1'b1);
        check("e3_bdata",  bus.bdata,  8'hA5);
        tick();
        check("e4_bvalid", bus.bvalid,    1'b0);
        check("e4_ack",    bus.b_ack_tgl, 1'b1);
        check("e4_cnt",    bus.rx_cnt,    8'd1);

        // Consumer stall
        bus.bload = 1'b0;
        send(8'h5A);
        wait_valid(10);
        repeat (10) begin
            tick();
            check("stall_bdata", bus.bdata,     8'h5A);
            check("stall_ack",   bus.b_ack_tgl, 1'b1);
        end
        bus.bload = 1'b1;
        tick();
        check("stall_accept_ack", bus.b_ack_tgl, 1'b0);
        check("stall_accept_cnt", bus.rx_cnt,    8'd2);
        bus.bload = 1'b0;

        // Overrun while holding a word
        send(8'hA5);
        wait_valid(10);
        send(8'h3C);
        repeat (4) tick();
        check("ovr_flag",  bus.overrun, 1'b1);
        check("ovr_bdata", bus.bdata,   8'hA5);
        bus.bload = 1'b1;
        tick();
        check("ovr_accept_bvalid", bus.bvalid, 1'b0);
        bus.bload = 1'b0;
        repeat (6) begin
            tick();
            check("ovr_no_3c", bus.bvalid, 1'b0);
        end

        // load_pulse and bload on the same edge
        do_reset(2);
        send(8'h11);
        wait_valid(10);
        check("sim_pre_ovr", bus.overrun, 1'b0);
        send(8'h22);
        tick();
        tick();
        bus.bload = 1'b1;
        tick();
        bus.bload = 1'b0;
        check("sim_ack",    bus.b_ack_tgl, 1'b1);
        check("sim_cnt",    bus.rx_cnt,    8'd1);
        check("sim_ovr",    bus.overrun,   1'b1);
        check("sim_bvalid", bus.bvalid,    1'b0);
        repeat (4) tick();

        // Toggle already high when reset releases
        bus.a_en_tgl = 1'b1;
        bus.adata    = 8'h77;
        do_reset(2);
        wait_valid(8);
        check("rel_bdata", bus.bdata, 8'h77);
        bus.bload = 1'b1;
        tick();
        bus.bload = 1'b0;

        // Random traffic including violations and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) send(8'($urandom));
            bus.bload = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                rstn = 1'b0;
                bus.a_en_tgl = 1'b0;
            end
            tick();
            rstn = 1'b1;
        end
        bus.bload = 1'b1;
        repeat (6) tick();
        bus.bload = 1'b0;

        // 256 transfers wrap the counter, then reset while holding a word
        bus.a_en_tgl = 1'b0;
        do_reset(2);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            wait_valid(8);
            bus.bload = 1'b1;
            tick();
            bus.bload = 1'b0;
        end
        check("wrap_cnt", bus.rx_cnt, 8'd0);
        send(8'hE7);
        wait_valid(8);
        rstn = 1'b0;
        bus.a_en_tgl = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_bvalid",  bus.bvalid,    1'b0);
        check("midrst_bdata",   bus.bdata,     8'h00);
        check("midrst_ack",     bus.b_ack_tgl, 1'b0);
        check("midrst_overrun", bus.overrun,   1'b0);
        check("midrst_cnt",     bus.rx_cnt,    8'd0);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
